// File: rtl/leaf_uplink_arbiter.sv
// Leaf uplink stage: four per-source FIFOs, round-robin source arbitration, round-robin spread over non-full spine uplinks.
// Optional macro LEAF_UPLINK_DROP_CNT_EN builds the per-source saturating drop counters; otherwise drop_cnt is tied to zero.
module leaf_uplink_arbiter #(
   parameter int DWIDTH     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int LEAF_ID    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] src0_in_data,
   input  logic [DWIDTH-1:0] src1_in_data,
   input  logic [DWIDTH-1:0] src2_in_data,
   input  logic [DWIDTH-1:0] src3_in_data,
   input  logic              src0_in_valid,
   input  logic              src1_in_valid,
   input  logic              src2_in_valid,
   input  logic              src3_in_valid,
   output logic [3:0]        src_full,
   output logic [DWIDTH-1:0] up1_out_data,
   output logic [DWIDTH-1:0] up2_out_data,
   output logic [DWIDTH-1:0] up3_out_data,
   output logic [DWIDTH-1:0] up4_out_data,
   output logic              up1_out_valid,
   output logic              up2_out_valid,
   output logic              up3_out_valid,
   output logic              up4_out_valid,
   input  logic [3:0]        up_full,
   output logic [31:0]       drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LEAF_ID < 0 || LEAF_ID > 3) begin : g_bad_param
      $error("leaf_uplink_arbiter: FIFO_DEPTH must be a power of two >= 2 and LEAF_ID must fit in 2 bits");
   end

   logic [DWIDTH-1:0] src_data [4];
   logic [DWIDTH-1:0] head_data [4];
   logic [DWIDTH-1:0] up_data_reg [4];
   logic [3:0]        src_valid;
   logic [3:0]        fifo_empty;
   logic [3:0]        push;
   logic [3:0]        pop;
   logic [3:0]        up_valid_reg;
   logic [1:0]        rr_src_reg;
   logic [1:0]        rr_up_reg;
   logic [1:0]        src_sel;
   logic [1:0]        up_sel;
   logic              src_found;
   logic              up_found;
   logic              grant;

   assign src_data[0] = src0_in_data;
   assign src_data[1] = src1_in_data;
   assign src_data[2] = src2_in_data;
   assign src_data[3] = src3_in_data;
   assign src_valid   = {src3_in_valid, src2_in_valid, src1_in_valid, src0_in_valid};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_src
         logic [DWIDTH-1:0] mem [FIFO_DEPTH];
         logic [AW-1:0]     wr_ptr_reg;
         logic [AW-1:0]     rd_ptr_reg;
         logic [AW:0]       count_reg;

         // Fullness comes from the registered count, so a same-cycle pop never rescues a write.
         assign src_full[gi]   = (count_reg == DEPTH_CNT);
         assign fifo_empty[gi] = (count_reg == '0);
         assign push[gi]       = src_valid[gi] && !src_full[gi];
         assign pop[gi]        = grant && (src_sel == 2'(gi));
         assign head_data[gi]  = mem[rd_ptr_reg];

         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem[wr_ptr_reg] <= src_data[gi];
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push[gi]) begin
                  wr_ptr_reg <= wr_ptr_reg + AW'(1);
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + AW'(1);
               end
               case ({push[gi], pop[gi]})
                  2'b10:   count_reg <= count_reg + (AW+1)'(1);
                  2'b01:   count_reg <= count_reg - (AW+1)'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

   // Both searches scan four slots starting at their own round-robin pointer.
   always_comb begin
      src_sel   = rr_src_reg;
      src_found = 1'b0;
      up_sel    = rr_up_reg;
      up_found  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!src_found && !fifo_empty[rr_src_reg + 2'(k)]) begin
            src_found = 1'b1;
            src_sel   = rr_src_reg + 2'(k);
         end
         if (!up_found && !up_full[rr_up_reg + 2'(k)]) begin
            up_found = 1'b1;
            up_sel   = rr_up_reg + 2'(k);
         end
      end
      grant = src_found && up_found;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_src_reg   <= '0;
         rr_up_reg    <= '0;
         up_valid_reg <= '0;
         for (int j = 0; j < 4; j++) begin
            up_data_reg[j] <= '0;
         end
      end else begin
         up_valid_reg <= '0;
         if (grant) begin
            rr_src_reg              <= src_sel + 2'd1;
            rr_up_reg               <= up_sel + 2'd1;
            up_valid_reg[up_sel]    <= 1'b1;
            up_data_reg[up_sel]     <= head_data[src_sel];
         end
      end
   end

   assign up1_out_data  = up_data_reg[0];
   assign up2_out_data  = up_data_reg[1];
   assign up3_out_data  = up_data_reg[2];
   assign up4_out_data  = up_data_reg[3];
   assign up1_out_valid = up_valid_reg[0];
   assign up2_out_valid = up_valid_reg[1];
   assign up3_out_valid = up_valid_reg[2];
   assign up4_out_valid = up_valid_reg[3];

`ifdef LEAF_UPLINK_DROP_CNT_EN
   generate
      for (gi = 0; gi < 4; gi++) begin : g_drop
         logic [7:0] drop_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               drop_reg <= '0;
            end else if (src_valid[gi] && src_full[gi] && drop_reg != 8'hFF) begin
               drop_reg <= drop_reg + 8'd1;
            end
         end

         assign drop_cnt[8*gi +: 8] = drop_reg;
      end
   endgenerate
`else
   assign drop_cnt = 32'h0;
`endif

endmodule

// File: doc/leaf_uplink_arbiter.md
# leaf_uplink_arbiter

Leaf-side uplink stage that sits directly upstream of the spine routers in a group. It buffers flits from four local source ports in per-source FIFOs and arbitrates them round-robin, one flit per cycle. Each flit goes out on one of four spine uplinks, spread round-robin across the uplinks that are not full. Uplink outputs drive the leaf-port inputs of spine routers 1–4; each spine port's input-FIFO-full flag feeds back as that uplink's `up_full` bit.

## Interface
- `DWIDTH`, 16, flit width; flits are forwarded unmodified.
- `FIFO_DEPTH`, 8, entries per source FIFO; must be a power of two, ≥ 2.
- `LEAF_ID`, 1, leaf identifier, 2 bits; informational, not used in the datapath.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src0_in_data`..`src3_in_data`  in  DWIDTH  source flit data.
- `src0_in_valid`..`src3_in_valid`  in  1  source flit valid.
- `src_full`  out  4  bit i = 1 when source FIFO i holds FIFO_DEPTH entries.
- `up1_out_data`..`up4_out_data`  out  DWIDTH  uplink flit data, registered.
- `up1_out_valid`..`up4_out_valid`  out  1  uplink flit valid, registered.
- `up_full`  in  4  bit j−1 = 1 means uplink j must not be granted this cycle.
- `drop_cnt`  out  32  four 8-bit saturating drop counters; source i occupies bits [8i+7:8i].

## Operation
- **Write**: on each edge, for every source i with `srcN_in_valid`=1:
  - if FIFO i is not full, the flit is pushed;
  - if FIFO i is full, the flit is dropped and drop counter i increments, saturating at 255.
  - Full is evaluated from the count registered at the start of the cycle. A pop in the same cycle does not rescue the write.
- **Source arbitration**: a round-robin pointer `rr_src` (2 bits) selects the candidate.
  - Starting at `rr_src`, the first non-empty FIFO is the winner.
  - After a grant to source i, `rr_src` becomes (i+1) mod 4. With no grant it holds.
- **Uplink selection**: a round-robin pointer `rr_up` selects the uplink.
  - Starting at `rr_up`, the first uplink j with `up_full[j-1]`=0 is chosen.
  - After a grant, `rr_up` advances to one past the chosen uplink, mod 4.
- **Grant** requires a non-empty source and a non-full uplink. On a grant:
  - the head flit is popped;
  - `upJ_out_data` is registered with the flit and `upJ_out_valid`=1 for exactly one cycle;
  - every other uplink's valid is 0.
- **No grant**: all four uplink valids are 0 and both pointers hold.
- Uplink data registers hold their last value when valid is 0.
- **Per-source ordering**: flits from one source leave in arrival order. They may be spread across different uplinks.
- **Datapath**: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Counts are log2(FIFO_DEPTH)+1 bits.
- **Reset**: asserting `reset` low takes effect asynchronously, including mid-stream, and forces:
  - all `upJ_out_valid` = 0 and all `upJ_out_data` = 0;
  - FIFOs empty, `src_full` = 0;
  - `rr_src` = 0, `rr_up` = 0;
  - `drop_cnt` = 0.
- Flits presented while reset is low are ignored. No stale flit emerges after release.

## Timing
- Latency into an empty FIFO with a free uplink: a flit sampled at edge k is popped and registered at edge k+1. `upJ_out_valid` is therefore high during the cycle following edge k+1, i.e. 2 cycles from input.
- Throughput: 1 flit per cycle aggregate across all uplinks.
- `src_full` is combinational from the registered count. It is valid in the same cycle as the count update.
- `up_full` is sampled at the grant edge. A flit already registered on an uplink is not recalled if that uplink's `up_full` rises afterwards.
- `drop_cnt` updates on the edge the drop occurs.

## Configuration
- Macro: `LEAF_UPLINK_DROP_CNT_EN`.
- Defined: the four 8-bit saturating drop counters are implemented as described above.
- Undefined: the counters are not built and `drop_cnt` is tied to 32'h0. Drop behaviour and all other behaviour are unchanged.

## Test plan
- **Single flit**: `src0` 16'hA5A5 for one cycle after reset release, `up_full`=0 → `up1_out_valid`=1 and `up1_out_data`=16'hA5A5, two cycles later, for one cycle.
- **Fairness**: 16'h0001..16'h0004 on `src0`..`src3` in the same cycle, `up_full`=0 → on consecutive cycles, src0→up1, src1→up2, src2→up3, src3→up4.
- **Uplink skip**: `up_full`=4'b0011, 4 flits from `src1` → flits alternate up3, up4, up3, up4; up1 and up2 valid never assert.
- **Full/drop**: `up_full`=4'hF, 9 back-to-back flits 1..9 on `src2` → after the 8th, `src_full[2]`=1; flit 9 is dropped; `drop_cnt[23:16]`=1. Then set `up_full`=0 → flits 1..8 emerge in order, and `src_full[2]` clears after the first pop.
- **Saturation**: `up_full`=4'hF, `src3` valid continuously for 300 cycles → `drop_cnt[31:24]` reaches 255 and holds.
- **Reset mid-stream**: reset asserted while 5 flits are queued and an uplink valid is high → all valids drop to 0 immediately, `drop_cnt`=0, `src_full`=0. After release with no input, no uplink valid asserts for 10 cycles.
